// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// State encoding plus the frame-length formula.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Clocks from first start-bit cycle to the sent pulse inclusive
    function automatic int frame_clks(
        input int dwidth,
        input int cpb,
        input int par_en,
        input int stop_bits
    );
        return (1 + dwidth + par_en + stop_bits) * cpb;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1; tick marks the last cycle of a bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick,
    output logic near_tick
);

    localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

    logic [W-1:0] cnt;

    // Restart on state entry, wrap at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick      = (cnt == LAST);
    // High one cycle before tick, lets registered outputs line up with it
    assign near_tick = (cnt == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer that serialises each byte as a UART frame.
// Start bit, LSB-first data, optional even parity, 1 or 2 stop bits.
module fifo_uart_tx #(
    parameter int DWIDTH       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              txd,
    output logic              busy,
    output logic              sent
);

    import fifo_uart_pkg::*;

    localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DWIDTH - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    tx_state_t         state, state_n;
    logic [DWIDTH-1:0] shreg, shreg_n;
    logic              par, par_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic              stop_cnt, stop_cnt_n;
    logic              fetch_q;
    logic              txd_n, rd_n, sent_n;
    logic              clr, tick, near_tick;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .tick     (tick),
        .near_tick(near_tick)
    );

    // State, datapath and registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            par      <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            fetch_q  <= 1'b0;
            txd      <= 1'b1;
            fifo_rd  <= 1'b0;
            sent     <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            par      <= par_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            fetch_q  <= (state == FETCH);
            txd      <= txd_n;
            fifo_rd  <= rd_n;
            sent     <= sent_n;
        end
    end

    // Next state, datapath update and next pin values
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        par_n      = par;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;

        // The popped byte appears the cycle after the FETCH strobe
        if (fetch_q) begin
            shreg_n = fifo_data;
            par_n   = ^fifo_data;
        end

        unique case (state)
            IDLE: begin
                if (en && !fifo_empty) state_n = FETCH;
            end
            FETCH: begin
                state_n = START;
            end
            START: begin
                if (tick) state_n = DATA;
            end
            DATA: begin
                if (tick) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) state_n = STOP;
            end
            STOP: begin
                if (tick) begin
                    stop_cnt_n = stop_cnt + 1'b1;
                    if (stop_cnt == STOP_LAST) begin
                        state_n = (en && !fifo_empty) ? FETCH : IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n != state) begin
            bit_cnt_n  = '0;
            stop_cnt_n = 1'b0;
        end

        clr = (state_n != state) || (state == IDLE);

        unique case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shreg_n[0];
            PARITY:  txd_n = par_n;
            default: txd_n = 1'b1;
        endcase

        rd_n   = (state_n == FETCH);
        sent_n = (state == STOP) && (stop_cnt == STOP_LAST) && near_tick;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: two instances, one plain 8N1,
// one with even parity and two stop bits, each fed by a FIFO model.
module tb_fifo_uart_tx;

    import fifo_uart_pkg::*;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] en = 2'b00;
    logic [1:0] fifo_empty;
    logic [1:0] fifo_rd;
    logic [1:0] txd;
    logic [1:0] busy;
    logic [1:0] sent;
    logic [7:0] fdata0 = 8'h00;
    logic [7:0] fdata1 = 8'h00;

    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];
    int wp0 = 0;
    int rp0 = 0;
    int wp1 = 0;
    int rp1 = 0;

    logic [8:0] expq0 [$];
    logic [8:0] expq1 [$];

    int checks = 0;
    int errors = 0;

    int   ph [2] = '{-1, -1};
    int   idle [2] = '{0, 0};
    int   gap1 [2] = '{0, 0};
    int   sentcnt [2] = '{0, 0};
    int   rdcnt [2] = '{0, 0};
    logic hold [2];
    logic [7:0] rx [2];
    logic rpar;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DWIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en[0]),
        .fifo_empty(fifo_empty[0]), .fifo_data(fdata0),
        .fifo_rd(fifo_rd[0]), .txd(txd[0]),
        .busy(busy[0]), .sent(sent[0])
    );

    fifo_uart_tx #(
        .DWIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en[1]),
        .fifo_empty(fifo_empty[1]), .fifo_data(fdata1),
        .fifo_rd(fifo_rd[1]), .txd(txd[1]),
        .busy(busy[1]), .sent(sent[1])
    );

    assign fifo_empty[0] = (wp0 == rp0);
    assign fifo_empty[1] = (wp1 == rp1);

    // FIFO models: registered read data, one clock after the strobe
    always @(posedge clk) begin
        if (fifo_rd[0]) begin
            fdata0 <= mem0[rp0 % 32];
            rp0 <= rp0 + 1;
        end
        if (fifo_rd[1]) begin
            fdata1 <= mem1[rp1 % 32];
            rp1 <= rp1 + 1;
        end
    end

    function automatic void chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, want, $time);
        end
    endfunction

    function automatic int flen(input int i);
        return (i == 0) ? 40 : 48;
    endfunction

    function automatic int stop_k(input int i);
        return (i == 0) ? 9 : 10;
    endfunction

    // Monitor: decodes frames on txd and checks them against the queues
    always @(negedge clk) begin
        int k;
        int c;
        logic [8:0] e;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                ph[i] = -1;
                idle[i] = 0;
            end else begin
                if (ph[i] < 0) begin
                    if (txd[i] == 1'b0) begin
                        ph[i] = 0;
                        if (idle[i] == 1) gap1[i]++;
                    end else begin
                        idle[i]++;
                    end
                end else begin
                    ph[i]++;
                end
                if (ph[i] >= 0) begin
                    k = ph[i] / CPB;
                    c = ph[i] % CPB;
                    if (c == 0) hold[i] = txd[i];
                    else chk("bit_hold", int'(txd[i]), int'(hold[i]));
                    if (c == CPB / 2) begin
                        if (k >= 1 && k <= 8) rx[i][k-1] = txd[i];
                        else if (i == 1 && k == 9) rpar = txd[i];
                        else if (k >= stop_k(i)) chk("stop_bit", int'(txd[i]), 1);
                    end
                    if (ph[i] == flen(i) - 1) begin
                        chk("sent_time", int'(sent[i]), 1);
                        sentcnt[i]++;
                        if (i == 0 && expq0.size() > 0) begin
                            e = expq0.pop_front();
                            chk("frame_a_data", int'(rx[0]), int'(e[7:0]));
                        end else if (i == 1 && expq1.size() > 0) begin
                            e = expq1.pop_front();
                            chk("frame_b_data", int'(rx[1]), int'(e[7:0]));
                            chk("frame_b_parity", int'(rpar), int'(e[8]));
                        end else begin
                            chk("unexpected_frame", i, -1);
                        end
                        ph[i] = -1;
                        idle[i] = 0;
                    end else if (sent[i]) begin
                        chk("sent_early", ph[i], flen(i) - 1);
                    end
                end else if (sent[i]) begin
                    chk("sent_idle", 1, 0);
                end
                if (fifo_rd[i]) begin
                    rdcnt[i]++;
                    chk("rd_nonempty", int'(fifo_empty[i]), 0);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic p);
        if (i == 0) begin
            mem0[wp0 % 32] = d;
            wp0++;
            expq0.push_back({p, d});
        end else begin
            mem1[wp1 % 32] = d;
            wp1++;
            expq1.push_back({p, d});
        end
    endtask

    task automatic wait_sent(input int i, input int target, input int budget,
                             input string nm);
        int n;
        n = 0;
        while (sentcnt[i] < target && n < budget) begin
            cyc();
            n++;
        end
        if (sentcnt[i] < target) chk(nm, sentcnt[i], target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int r;
        int s;
        logic bad;
        int fr;

        fr = frame_clks(8, CPB, 1, 2) + 8;

        repeat (3) cyc();
        chk("rst_txd", int'(txd), 3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd", int'(fifo_rd), 0);
        chk("rst_sent", int'(sent), 0);
        rst_n = 1'b1;
        cyc();

        // Single byte 0xA5
        push(0, 8'hA5, 1'b0);
        en[0] = 1'b1;
        wait_sent(0, 1, fr, "t1_timeout");
        cyc();
        chk("t1_busy_idle", int'(busy[0]), 0);
        chk("t1_rd_pulses", rdcnt[0], 1);

        // Back-to-back stream 0..7
        g = gap1[0];
        r = rdcnt[0];
        for (int b = 0; b < 8; b++) push(0, 8'(b), 1'b0);
        wait_sent(0, 9, 9 * fr, "t2_timeout");
        cyc();
        chk("t2_gap1", gap1[0] - g, 7);
        chk("t2_rd_pulses", rdcnt[0] - r, 8);
        chk("t2_busy_idle", int'(busy[0]), 0);

        // Gating with en low
        en[0] = 1'b0;
        push(0, 8'h3C, 1'b0);
        bad = 1'b0;
        repeat (100) begin
            cyc();
            if (fifo_rd[0] || !txd[0] || busy[0]) bad = 1'b1;
        end
        chk("gate_idle", int'(bad), 0);
        en[0] = 1'b1;
        cyc();
        chk("en_fetch", int'(fifo_rd[0]), 1);
        wait_sent(0, 10, fr, "t3_timeout");

        // Reset during data bit 3 of 0xF0, then 0x5A must follow intact
        s = sentcnt[0];
        push(0, 8'hF0, 1'b0);
        push(0, 8'h5A, 1'b0);
        bad = 1'b1;
        for (int n = 0; n < 20 && bad; n++) begin
            cyc();
            if (!txd[0]) bad = 1'b0;
        end
        chk("t4_start_seen", int'(bad), 0);
        repeat (18) cyc();
        rst_n = 1'b0;
        #1;
        chk("t4_rst_txd", int'(txd[0]), 1);
        chk("t4_rst_busy", int'(busy[0]), 0);
        chk("t4_rst_rd", int'(fifo_rd[0]), 0);
        if (expq0.size() > 0) void'(expq0.pop_front());
        repeat (2) cyc();
        rst_n = 1'b1;
        wait_sent(0, s + 1, 2 * fr, "t4_timeout");
        cyc();
        chk("t4_sent_once", sentcnt[0] - s, 1);
        chk("t4_busy_idle", int'(busy[0]), 0);

        // Parity and two stop bits: 0x07 -> 1, 0x03 -> 0
        g = gap1[1];
        en[1] = 1'b1;
        push(1, 8'h07, 1'b1);
        push(1, 8'h03, 1'b0);
        wait_sent(1, 2, 3 * fr, "t5_timeout");
        cyc();
        chk("t5_gap1", gap1[1] - g, 1);
        chk("t5_busy_idle", int'(busy[1]), 0);
        chk("t5_rd_pulses", rdcnt[1], 2);

        chk("exp_drained", expq0.size() + expq1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
